voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_if.sv | 25 ++
 rtl/voice_allocator.sv | 186 ++++++++++++++++++
 tb/tb_voice_allocator.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// Command and status bundle between a note source (master) and the voice allocator (slave).
interface voice_allocator_if;
    logic       i_note_on;
    logic       i_note_off;
    logic [6:0] i_note;
    logic [7:0] i_velocity;
    logic [7:0] i_prepped;
    logic       o_cmd_ready;
    logic [7:0] o_go;
    logic [7:0] o_release;
    logic [7:0] o_active;
    logic [7:0] o_vel_out;
    logic       o_stole;
    logic       o_dropped;

    modport master (
        output i_note_on, i_note_off, i_note, i_velocity, i_prepped,
        input  o_cmd_ready, o_go, o_release, o_active, o_vel_out, o_stole, o_dropped
    );

    modport slave (
        input  i_note_on, i_note_off, i_note, i_velocity, i_prepped,
        output o_cmd_ready, o_go, o_release, o_active, o_vel_out, o_stole, o_dropped
    );
endinterface

// File: rtl/voice_allocator.sv
// Eight-voice note allocator: lowest free voice first, otherwise steal the oldest
// active voice and wait (bounded) for it to report prepped before issuing go.
module voice_allocator #(
    parameter bit          STEAL_EN     = 1'b1,
    parameter int unsigned PREP_TIMEOUT = 1023
) (
    input logic              clk,
    input logic              reset,
    voice_allocator_if.slave bus
);
    localparam int unsigned NV = 8;
    localparam int unsigned VW = 3;
    localparam int unsigned NW = 7;
    localparam int unsigned AW = 3;
    localparam int unsigned CW = 10;
    localparam int unsigned TW = CW + 1;
    localparam logic [AW-1:0] AGE_MAX = '1;

    typedef enum logic [1:0] {IDLE, ALLOC, WAIT_PREP, ISSUE} state_t;

    state_t        r_state;
    logic [NW-1:0] r_note;
    logic [7:0]    r_vel;
    logic [VW-1:0] r_voice;
    logic [CW-1:0] r_cnt;
    logic [NW-1:0] r_tag [NV];
    logic [AW-1:0] r_age [NV];
    logic          r_cmd_ready;
    logic [NV-1:0] r_go;
    logic [NV-1:0] r_release;
    logic [NV-1:0] r_active;
    logic [7:0]    r_vel_out;
    logic          r_stole;
    logic          r_dropped;

    logic [NV-1:0] w_free;
    logic [NV-1:0] w_match;
    logic          w_has_free;
    logic          w_has_active;
    logic          w_issue;
    logic          w_timeout;
    logic [VW-1:0] w_free_idx;
    logic [VW-1:0] w_steal_idx;
    logic [VW-1:0] w_issue_idx;
    logic [AW-1:0] w_best_age;

    assign w_free = bus.i_prepped & ~r_active;

    // Lowest-index free voice.
    always_comb begin : free_pick
        w_has_free = 1'b0;
        w_free_idx = '0;
        for (int i = int'(NV) - 1; i >= 0; i--) begin
            if (w_free[i]) begin
                w_has_free = 1'b1;
                w_free_idx = VW'(i);
            end
        end
    end

    // Oldest active voice; strict '>' keeps the lowest index on ties.
    always_comb begin : steal_pick
        w_has_active = 1'b0;
        w_steal_idx  = '0;
        w_best_age   = '0;
        for (int i = 0; i < int'(NV); i++) begin
            if (r_active[i] && (!w_has_active || (r_age[i] > w_best_age))) begin
                w_has_active = 1'b1;
                w_steal_idx  = VW'(i);
                w_best_age   = r_age[i];
            end
        end
    end

    always_comb begin : tag_match
        w_match = '0;
        for (int i = 0; i < int'(NV); i++) begin
            w_match[i] = r_active[i] && (r_tag[i] == bus.i_note);
        end
    end

    assign w_issue     = ((r_state == ALLOC) && w_has_free) ||
                         ((r_state == WAIT_PREP) && bus.i_prepped[r_voice]);
    assign w_issue_idx = (r_state == ALLOC) ? w_free_idx : r_voice;
    assign w_timeout   = (TW'(r_cnt) + TW'(1)) == TW'(PREP_TIMEOUT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_note      <= '0;
            r_vel       <= '0;
            r_voice     <= '0;
            r_cnt       <= '0;
            r_cmd_ready <= 1'b1;
            r_go        <= '0;
            r_release   <= '0;
            r_active    <= '0;
            r_vel_out   <= '0;
            r_stole     <= 1'b0;
            r_dropped   <= 1'b0;
            for (int i = 0; i < int'(NV); i++) begin
                r_tag[i] <= '0;
                r_age[i] <= '0;
            end
        end else begin
            r_go      <= '0;
            r_release <= '0;
            r_stole   <= 1'b0;
            r_dropped <= 1'b0;
            case (r_state)
                IDLE: begin
                    // note_off is resolved first so a same-cycle note_on sees the freed voices
                    if (bus.i_note_off) begin
                        r_release <= w_match;
                        r_active  <= r_active & ~w_match;
                    end
                    if (bus.i_note_on) begin
                        r_note      <= bus.i_note;
                        r_vel       <= bus.i_velocity;
                        r_state     <= ALLOC;
                        r_cmd_ready <= 1'b0;
                    end
                end
                ALLOC: begin
                    if (w_has_free) begin
                        r_state <= ISSUE;
                    end else if (STEAL_EN && w_has_active) begin
                        r_voice              <= w_steal_idx;
                        r_cnt                <= '0;
                        r_release            <= NV'(1) << w_steal_idx;
                        r_active[w_steal_idx] <= 1'b0;
                        r_stole              <= 1'b1;
                        r_state              <= WAIT_PREP;
                    end else begin
                        r_dropped   <= 1'b1;
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end
                end
                WAIT_PREP: begin
                    if (bus.i_prepped[r_voice]) begin
                        r_state <= ISSUE;
                    end else if (w_timeout) begin
                        r_dropped   <= 1'b1;
                        r_state     <= IDLE;
                        r_cmd_ready <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ISSUE: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
                default: begin
                    r_state     <= IDLE;
                    r_cmd_ready <= 1'b1;
                end
            endcase

            // Issue actions land together so go, active and vel_out are visible in the ISSUE cycle.
            if (w_issue) begin
                r_go                 <= NV'(1) << w_issue_idx;
                r_active[w_issue_idx] <= 1'b1;
                r_tag[w_issue_idx]    <= r_note;
                r_vel_out            <= r_vel;
                r_voice              <= w_issue_idx;
                for (int i = 0; i < int'(NV); i++) begin
                    if (VW'(i) == w_issue_idx) begin
                        r_age[i] <= '0;
                    end else if (r_active[i] && (r_age[i] != AGE_MAX)) begin
                        r_age[i] <= r_age[i] + AW'(1);
                    end
                end
            end
        end
    end

    assign bus.o_cmd_ready = r_cmd_ready;
    assign bus.o_go        = r_go;
    assign bus.o_release   = r_release;
    assign bus.o_active    = r_active;
    assign bus.o_vel_out   = r_vel_out;
    assign bus.o_stole     = r_stole;
    assign bus.o_dropped   = r_dropped;
endmodule

// File: tb/tb_voice_allocator.sv
// Directed plus randomized bench for voice_allocator against a behavioural voice-pool model.
module tb_voice_allocator;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    voice_allocator_if bus ();
    voice_allocator_if bus_ns ();

    voice_allocator #(.STEAL_EN(1'b1), .PREP_TIMEOUT(1023)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    voice_allocator #(.STEAL_EN(1'b0), .PREP_TIMEOUT(1023)) dut_ns (
        .clk(clk), .reset(reset), .bus(bus_ns)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model of the voice pool: ownership, note tags, relative ages, last issued velocity.
    logic [7:0] m_active;
    logic [6:0] m_tag [8];
    int         m_age [8];
    logic [7:0] m_vel;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_active = '0;
        m_vel    = '0;
        for (int i = 0; i < 8; i++) begin
            m_tag[i] = '0;
            m_age[i] = 0;
        end
    endtask

    function automatic logic [7:0] tag_mask(input logic [6:0] n);
        logic [7:0] m;
        m = '0;
        for (int i = 0; i < 8; i++)
            if (m_active[i] && (m_tag[i] == n)) m[i] = 1'b1;
        return m;
    endfunction

    task automatic model_issue(input int v, input logic [6:0] n, input logic [7:0] vel);
        for (int i = 0; i < 8; i++)
            if ((i != v) && m_active[i] && (m_age[i] < 7)) m_age[i] = m_age[i] + 1;
        m_age[v]    = 0;
        m_active[v] = 1'b1;
        m_tag[v]    = n;
        m_vel       = vel;
    endtask

    task automatic check_issue(input int v);
        logic [7:0] oh;
        oh = 8'(1) << v;
        check("issue_go", bus.o_go, oh);
        check("issue_active", bus.o_active, m_active);
        check("issue_vel", bus.o_vel_out, m_vel);
        check("issue_norel", bus.o_release, 8'h00);
        check("issue_nostole", bus.o_stole, 1'b0);
    endtask

    task automatic idle_inputs();
        bus.i_note_on = 0; bus.i_note_off = 0; bus.i_note = '0; bus.i_velocity = '0; bus.i_prepped = '0;
        bus_ns.i_note_on = 0; bus_ns.i_note_off = 0; bus_ns.i_note = '0;
        bus_ns.i_velocity = '0; bus_ns.i_prepped = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("rst_go", bus.o_go, 8'h00);
        check("rst_release", bus.o_release, 8'h00);
        check("rst_active", bus.o_active, 8'h00);
        check("rst_vel", bus.o_vel_out, 8'h00);
        check("rst_stole", bus.o_stole, 1'b0);
        check("rst_dropped", bus.o_dropped, 1'b0);
        reset = 1'b1;
        tick();
        check("rst_ready", bus.o_cmd_ready, 1'b1);
        model_clear();
    endtask

    // delay < 0: stolen voice never reports prepped (timeout path).
    task automatic note_on_txn(input logic [6:0] n, input logic [7:0] vel, input logic [7:0] prep,
                               input int delay, input bit off_en);
        logic [7:0] rel, mask;
        int fv, sv, maxage, waited;
        rel = off_en ? tag_mask(n) : 8'h00;
        bus.i_prepped = prep; bus.i_note = n; bus.i_velocity = vel;
        bus.i_note_on = 1'b1; bus.i_note_off = off_en;
        tick();
        bus.i_note_on = 1'b0; bus.i_note_off = 1'b0;
        m_active = m_active & ~rel;
        check("on_busy", bus.o_cmd_ready, 1'b0);
        check("on_off_release", bus.o_release, rel);
        check("on_off_active", bus.o_active, m_active);
        fv = -1;
        for (int i = 0; i < 8; i++) if ((fv < 0) && prep[i] && !m_active[i]) fv = i;
        maxage = -1;
        for (int i = 0; i < 8; i++) if (m_active[i] && (m_age[i] > maxage)) maxage = m_age[i];
        sv = -1;
        for (int i = 0; i < 8; i++) if ((sv < 0) && m_active[i] && (m_age[i] == maxage)) sv = i;
        tick();
        if (fv >= 0) begin
            model_issue(fv, n, vel);
            check_issue(fv);
        end else if (sv >= 0) begin
            mask = 8'(1) << sv;
            m_active[sv] = 1'b0;
            check("steal_release", bus.o_release, mask);
            check("steal_stole", bus.o_stole, 1'b1);
            check("steal_nogo", bus.o_go, 8'h00);
            check("steal_active", bus.o_active, m_active);
            bus.i_prepped = prep & ~mask;
            if (delay < 0) begin
                waited = 0;
                while ((waited < 1100) && (bus.o_dropped !== 1'b1)) begin
                    tick();
                    waited++;
                end
                check("timeout_cycles", waited, 1023);
                check("timeout_ready", bus.o_cmd_ready, 1'b1);
                check("timeout_nogo", bus.o_go, 8'h00);
            end else begin
                for (int k = 0; k < delay; k++) begin
                    bus.i_note_on  = 1'($urandom);
                    bus.i_note_off = 1'($urandom);
                    bus.i_note     = 7'($urandom);
                    tick();
                    check("wait_nogo", bus.o_go, 8'h00);
                    check("wait_norel", bus.o_release, 8'h00);
                end
                bus.i_note_on = 1'b0; bus.i_note_off = 1'b0; bus.i_note = n;
                bus.i_prepped = prep | mask;
                tick();
                model_issue(sv, n, vel);
                check_issue(sv);
            end
        end else begin
            check("drop_pulse", bus.o_dropped, 1'b1);
            check("drop_nogo", bus.o_go, 8'h00);
            check("drop_norel", bus.o_release, 8'h00);
            check("drop_ready", bus.o_cmd_ready, 1'b1);
            check("drop_vel", bus.o_vel_out, m_vel);
        end
        tick();
        check("end_ready", bus.o_cmd_ready, 1'b1);
        check("end_nogo", bus.o_go, 8'h00);
        check("end_nostole", bus.o_stole, 1'b0);
        check("end_nodrop", bus.o_dropped, 1'b0);
        check("end_active", bus.o_active, m_active);
    endtask

    task automatic note_off_txn(input logic [6:0] n);
        logic [7:0] rel;
        rel = tag_mask(n);
        bus.i_note = n;
        bus.i_note_off = 1'b1;
        tick();
        bus.i_note_off = 1'b0;
        m_active = m_active & ~rel;
        check("off_release", bus.o_release, rel);
        check("off_active", bus.o_active, m_active);
        check("off_ready", bus.o_cmd_ready, 1'b1);
        tick();
        check("off_clear", bus.o_release, 8'h00);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b0;
        model_clear();
        do_reset();

        // Single note into an empty pool.
        note_on_txn(7'd60, 8'd100, 8'hFF, 0, 1'b0);

        // Fill all voices, then steal voice 0 for note 70 after a 5-cycle prep wait.
        do_reset();
        for (int i = 0; i < 8; i++) note_on_txn(7'(60 + i), 8'(10 + i), 8'hFF, 0, 1'b0);
        note_on_txn(7'd70, 8'd90, 8'h00, 5, 1'b0);
        note_off_txn(7'd70);

        // Retrigger of note 62 takes a new voice; note_off releases both.
        do_reset();
        note_on_txn(7'd62, 8'd1, 8'hFF, 0, 1'b0);
        note_on_txn(7'd63, 8'd2, 8'hFF, 0, 1'b0);
        note_on_txn(7'd64, 8'd3, 8'hFF, 0, 1'b0);
        note_on_txn(7'd62, 8'd4, 8'hFF, 0, 1'b0);
        note_off_txn(7'd62);
        check("retrig_active", bus.o_active, 8'h06);

        // Simultaneous note_off + note_on, with and without the freed voice prepped.
        note_on_txn(7'd63, 8'd50, 8'h02, 0, 1'b1);
        note_on_txn(7'd64, 8'd51, 8'h00, 2, 1'b1);

        // Stolen voice never prepped.
        do_reset();
        for (int i = 0; i < 8; i++) note_on_txn(7'(60 + i), 8'(20 + i), 8'hFF, 0, 1'b0);
        note_on_txn(7'd71, 8'd7, 8'h00, -1, 1'b0);

        // Reset in the middle of WAIT_PREP.
        bus.i_prepped = 8'h00; bus.i_note = 7'd72; bus.i_velocity = 8'd9; bus.i_note_on = 1'b1;
        tick();
        bus.i_note_on = 1'b0;
        tick();
        check("pre_reset_stole", bus.o_stole, 1'b1);
        tick();
        reset = 1'b0;
        idle_inputs();
        #1;
        check("midrst_go", bus.o_go, 8'h00);
        check("midrst_release", bus.o_release, 8'h00);
        check("midrst_active", bus.o_active, 8'h00);
        check("midrst_vel", bus.o_vel_out, 8'h00);
        check("midrst_stole", bus.o_stole, 1'b0);
        check("midrst_dropped", bus.o_dropped, 1'b0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        tick();
        check("postrst_ready", bus.o_cmd_ready, 1'b1);
        check("postrst_nogo", bus.o_go, 8'h00);
        check("postrst_nodrop", bus.o_dropped, 1'b0);
        model_clear();
        note_on_txn(7'd20, 8'd33, 8'hFF, 0, 1'b0);

        // Randomized traffic over a small note range to force matches, retriggers and steals.
        do_reset();
        for (int t = 0; t < 60; t++) begin
            logic [7:0] prep;
            prep = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 9) < 6)
                note_on_txn(7'(60 + $urandom_range(0, 3)), 8'($urandom), prep,
                            int'($urandom_range(0, 4)), ($urandom_range(0, 3) == 0));
            else
                note_off_txn(7'(60 + $urandom_range(0, 3)));
        end

        // No-steal variant: full pool drops the note without go or release.
        for (int i = 0; i < 8; i++) begin
            bus_ns.i_prepped = 8'hFF; bus_ns.i_note = 7'(40 + i);
            bus_ns.i_velocity = 8'(i + 1); bus_ns.i_note_on = 1'b1;
            tick();
            bus_ns.i_note_on = 1'b0;
            tick();
            check("ns_go", bus_ns.o_go, 8'(1) << i);
            tick();
        end
        bus_ns.i_prepped = 8'h00; bus_ns.i_note = 7'd50; bus_ns.i_velocity = 8'd77;
        bus_ns.i_note_on = 1'b1;
        tick();
        bus_ns.i_note_on = 1'b0;
        check("ns_busy", bus_ns.o_cmd_ready, 1'b0);
        tick();
        check("ns_dropped", bus_ns.o_dropped, 1'b1);
        check("ns_nogo", bus_ns.o_go, 8'h00);
        check("ns_norel", bus_ns.o_release, 8'h00);
        check("ns_nostole", bus_ns.o_stole, 1'b0);
        check("ns_active", bus_ns.o_active, 8'hFF);
        check("ns_vel", bus_ns.o_vel_out, 8'd8);
        check("ns_ready", bus_ns.o_cmd_ready, 1'b1);
        tick();
        check("ns_drop_clear", bus_ns.o_dropped, 1'b0);
        check("ns_nogo_after", bus_ns.o_go, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
